// File: rtl/const_gen_pkg.sv
// Shared types and helpers for the programmable constant generator:
// FSM state encoding and the bit-counter width derivation.
package const_gen_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter must reach CFG_W+1 so an overrun frame is distinguishable.
  function automatic int cnt_width(input int cfg_w);
    return $clog2(cfg_w + 2);
  endfunction

endpackage

// File: rtl/const_gen_shift.sv
// Serial-in shift register (MSB first) with a saturating bit counter;
// the counter parks at CFG_W+1 on overrun while shifting continues.
module const_gen_shift
  import const_gen_pkg::*;
#(
  parameter int CFG_W = 16,
  parameter int CNT_W = cnt_width(16)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             dat,
  output logic [CFG_W-1:0] shift_q,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_W + 1);

  logic [CFG_W-1:0] shift_reg;
  logic [CFG_W-1:0] shift_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // A one-bit frame has no history to shift along.
  generate
    if (CFG_W == 1) begin : g_single
      assign shift_next = shift_en ? dat : shift_reg;
    end else begin : g_multi
      assign shift_next = shift_en ? {shift_reg[CFG_W-2:0], dat} : shift_reg;
    end
  endgenerate

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (shift_en && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign shift_q = shift_reg;
  assign cnt     = cnt_reg;

endmodule

// File: rtl/const_gen_prog.sv
// Constant tie-hi/tie-lo banks plus a serially loaded configuration register
// with commit handshake, sticky frame error and sticky lock.
module const_gen_prog
  import const_gen_pkg::*;
#(
  parameter int               NO_HI   = 32,
  parameter int               NO_LO   = 96,
  parameter int               CFG_W   = 16,
  parameter logic [CFG_W-1:0] CFG_RST = '0,
  parameter int               CNT_W   = cnt_width(CFG_W)
) (
`ifdef USE_POWER_PINS
  inout  wire              vccd1,
  inout  wire              vssd1,
`endif
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ser_en_i,
  input  logic             ser_dat_i,
  input  logic             commit_i,
  input  logic             lock_i,
  output logic [NO_HI-1:0] tie_hi,
  output logic [NO_LO-1:0] tie_lo,
  output logic [CFG_W-1:0] cfg_o,
  output logic             done_o,
  output logic             err_o,
  output logic             locked_o
);

  assign tie_hi = '1;
  assign tie_lo = '0;

  logic [CFG_W-1:0] shift_q;
  logic [CNT_W-1:0] cnt;
  logic             shift_en;
  logic             commit_ok;

  state_t           state_reg;
  state_t           state_next;
  logic [CFG_W-1:0] cfg_reg;
  logic [CFG_W-1:0] cfg_next;
  logic             done_reg;
  logic             done_next;
  logic             err_reg;
  logic             err_next;
  logic             locked_reg;
  logic             locked_next;

  // Commit has priority: the data bit presented alongside it is dropped.
  assign shift_en = ser_en_i & ~commit_i;

  const_gen_shift #(
    .CFG_W (CFG_W),
    .CNT_W (CNT_W)
  ) u_shift (
    .clk      (clk_i),
    .rst      (rst_i),
    .shift_en (shift_en),
    .clr      (commit_i),
    .dat      (ser_dat_i),
    .shift_q  (shift_q),
    .cnt      (cnt)
  );

  // Uses the pre-lock value, so a lock arriving with a good commit still lets it land.
  assign commit_ok = (cnt == CNT_W'(CFG_W)) && !locked_reg;

  always_comb begin
    state_next  = state_reg;
    cfg_next    = cfg_reg;
    done_next   = 1'b0;
    err_next    = err_reg;
    locked_next = locked_reg | lock_i;

    case (state_reg)
      IDLE:    if (ser_en_i) state_next = SHIFT;
      SHIFT:   state_next = SHIFT;
      default: state_next = IDLE;
    endcase

    if (commit_i) begin
      state_next = IDLE;
      if (commit_ok) begin
        cfg_next  = shift_q;
        done_next = 1'b1;
      end else begin
        err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      cfg_reg    <= CFG_RST;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      locked_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cfg_reg    <= cfg_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      locked_reg <= locked_next;
    end
  end

  assign cfg_o    = cfg_reg;
  assign done_o   = done_reg;
  assign err_o    = err_reg;
  assign locked_o = locked_reg;

endmodule

// File: tb/tb_const_gen_prog.sv
// Bench for const_gen_prog: frame-level reference model (bit queue per frame)
// driven by directed and randomized serial traffic.
module tb_const_gen_prog;

  localparam int               NO_HI     = 32;
  localparam int               NO_LO     = 96;
  localparam int               CFG_W     = 16;
  localparam logic [CFG_W-1:0] CFG_RST_V = 16'hA5C3;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             ser_en_i = 1'b0;
  logic             ser_dat_i = 1'b0;
  logic             commit_i = 1'b0;
  logic             lock_i = 1'b0;
  logic [NO_HI-1:0] tie_hi;
  logic [NO_LO-1:0] tie_lo;
  logic [CFG_W-1:0] cfg_o;
  logic             done_o;
  logic             err_o;
  logic             locked_o;

  int checks = 0;
  int errors = 0;

  // Reference model: bits received since the last commit, plus expected outputs.
  bit               mbits[$];
  logic [CFG_W-1:0] exp_cfg;
  logic             exp_done;
  logic             exp_err;
  logic             exp_locked;

  const_gen_prog #(
    .NO_HI   (NO_HI),
    .NO_LO   (NO_LO),
    .CFG_W   (CFG_W),
    .CFG_RST (CFG_RST_V)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .ser_en_i  (ser_en_i),
    .ser_dat_i (ser_dat_i),
    .commit_i  (commit_i),
    .lock_i    (lock_i),
    .tie_hi    (tie_hi),
    .tie_lo    (tie_lo),
    .cfg_o     (cfg_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .locked_o  (locked_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [CFG_W-1:0] frame_word();
    logic [CFG_W-1:0] w = '0;
    foreach (mbits[i]) w = {w[CFG_W-2:0], mbits[i]};
    return w;
  endfunction

  task automatic model_reset();
    mbits.delete();
    exp_cfg    = CFG_RST_V;
    exp_done   = 1'b0;
    exp_err    = 1'b0;
    exp_locked = 1'b0;
  endtask

  // One clock: apply inputs, advance past the edge, update the model.
  task automatic step(input bit en, input bit dat, input bit com, input bit lk);
    ser_en_i  = en;
    ser_dat_i = dat;
    commit_i  = com;
    lock_i    = lk;
    @(posedge clk_i);
    #1;
    exp_done = 1'b0;
    if (com) begin
      if (mbits.size() == CFG_W && !exp_locked) begin
        exp_cfg  = frame_word();
        exp_done = 1'b1;
      end else begin
        exp_err = 1'b1;
      end
      mbits.delete();
    end else if (en) begin
      mbits.push_back(dat);
    end
    if (lk) exp_locked = 1'b1;
    ser_en_i  = 1'b0;
    ser_dat_i = 1'b0;
    commit_i  = 1'b0;
    lock_i    = 1'b0;
  endtask

  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, w[i], 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk_i);
    #2;
    checks++;
    if (cfg_o !== CFG_RST_V) begin errors++; $display("FAIL reset_cfg got %h want %h", cfg_o, CFG_RST_V); end
    checks++;
    if (err_o !== 1'b0 || locked_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL reset_flags got err=%b locked=%b done=%b want 0 0 0", err_o, locked_o, done_o);
    end
    checks++;
    if (tie_hi !== {NO_HI{1'b1}}) begin errors++; $display("FAIL tie_hi got %h", tie_hi); end
    checks++;
    if (tie_lo !== {NO_LO{1'b0}}) begin errors++; $display("FAIL tie_lo got %h", tie_lo); end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    $display("reset: cfg_o=%h err=%b locked=%b", cfg_o, err_o, locked_o);
  endtask

  task automatic test_commit();
    shift_bits(32'h1234, CFG_W);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (cfg_o !== exp_cfg || exp_cfg !== 16'h1234) begin errors++; $display("FAIL commit_cfg got %h want %h", cfg_o, exp_cfg); end
    checks++;
    if (done_o !== 1'b1 || err_o !== 1'b0) begin errors++; $display("FAIL commit_done got done=%b err=%b want 1 0", done_o, err_o); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (done_o !== 1'b0) begin errors++; $display("FAIL commit_pulse got done=%b want 0", done_o); end
    $display("commit: cfg_o=%h", cfg_o);
  endtask

  task automatic test_short_long();
    int lens[2] = '{15, 17};
    do_reset();
    shift_bits(32'h1234, CFG_W);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    foreach (lens[k]) begin
      shift_bits($urandom, lens[k]);
      checks++;
      if (err_o !== exp_err) begin errors++; $display("FAIL frame_pre_err len=%0d got %b want %b", lens[k], err_o, exp_err); end
      step(1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (cfg_o !== exp_cfg || done_o !== 1'b0 || err_o !== 1'b1) begin
        errors++; $display("FAIL bad_len len=%0d got cfg=%h done=%b err=%b want cfg=%h done=0 err=1",
                           lens[k], cfg_o, done_o, err_o, exp_cfg);
      end
      $display("bad frame len=%0d: cfg_o=%h err=%b", lens[k], cfg_o, err_o);
    end
  endtask

  task automatic test_collision();
    do_reset();
    shift_bits($urandom, CFG_W - 1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (err_o !== 1'b1 || done_o !== 1'b0 || cfg_o !== CFG_RST_V) begin
      errors++; $display("FAIL collision got err=%b done=%b cfg=%h want 1 0 %h", err_o, done_o, cfg_o, CFG_RST_V);
    end
    shift_bits(32'h00FF, CFG_W);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (cfg_o !== 16'h00FF || done_o !== 1'b1) begin
      errors++; $display("FAIL after_collision got cfg=%h done=%b want 00ff 1", cfg_o, done_o);
    end
    $display("collision: err=%b then cfg_o=%h", err_o, cfg_o);
  endtask

  task automatic test_random();
    int lens[6] = '{0, 15, 16, 16, 16, 17};
    do_reset();
    for (int f = 0; f < 24; f++) begin
      int n = lens[$urandom_range(5, 0)];
      logic [31:0] w = $urandom;
      for (int i = n - 1; i >= 0; i--) begin
        if ($urandom_range(3, 0) == 0) step(1'b0, 1'($urandom), 1'b0, 1'b0);
        step(1'b1, w[i], 1'b0, 1'b0);
        checks++;
        if (cfg_o !== exp_cfg || done_o !== exp_done || err_o !== exp_err) begin
          errors++; $display("FAIL rand_shift f=%0d got cfg=%h done=%b err=%b want %h %b %b",
                             f, cfg_o, done_o, err_o, exp_cfg, exp_done, exp_err);
        end
      end
      step(1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (cfg_o !== exp_cfg || done_o !== exp_done || err_o !== exp_err) begin
        errors++; $display("FAIL rand_commit f=%0d len=%0d got cfg=%h done=%b err=%b want %h %b %b",
                           f, n, cfg_o, done_o, err_o, exp_cfg, exp_done, exp_err);
      end
      $display("random frame %0d len=%0d: cfg_o=%h done=%b err=%b", f, n, cfg_o, done_o, err_o);
    end
  endtask

  task automatic test_lock();
    do_reset();
    shift_bits(32'hBEEF, CFG_W);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (cfg_o !== 16'hBEEF || locked_o !== 1'b1 || done_o !== 1'b1 || err_o !== 1'b0) begin
      errors++; $display("FAIL lock_commit got cfg=%h locked=%b done=%b err=%b want beef 1 1 0",
                         cfg_o, locked_o, done_o, err_o);
    end
    shift_bits(32'h0000, CFG_W);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (cfg_o !== exp_cfg || cfg_o !== 16'hBEEF || err_o !== 1'b1 || done_o !== 1'b0 || locked_o !== 1'b1) begin
      errors++; $display("FAIL locked_commit got cfg=%h err=%b done=%b locked=%b want beef 1 0 1",
                         cfg_o, err_o, done_o, locked_o);
    end
    $display("lock: cfg_o=%h locked=%b err=%b", cfg_o, locked_o, err_o);
  endtask

  task automatic test_async_reset();
    logic [31:0] w;
    do_reset();
    shift_bits(32'h1234, CFG_W);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (cfg_o !== 16'h1234 || locked_o !== 1'b1 || err_o !== 1'b1) begin
      errors++; $display("FAIL pre_async got cfg=%h locked=%b err=%b want 1234 1 1", cfg_o, locked_o, err_o);
    end
    shift_bits($urandom, 5);
    #2;
    rst_i = 1'b1;
    #1;
    model_reset();
    checks++;
    if (cfg_o !== CFG_RST_V || locked_o !== 1'b0 || err_o !== 1'b0) begin
      errors++; $display("FAIL async_reset got cfg=%h locked=%b err=%b want %h 0 0", cfg_o, locked_o, err_o, CFG_RST_V);
    end
    @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    w = $urandom;
    shift_bits(w, CFG_W);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (cfg_o !== w[CFG_W-1:0] || cfg_o !== exp_cfg || done_o !== 1'b1 || err_o !== 1'b0) begin
      errors++; $display("FAIL post_reset_frame got cfg=%h done=%b err=%b want %h 1 0", cfg_o, done_o, err_o, w[CFG_W-1:0]);
    end
    $display("async reset: fresh frame cfg_o=%h", cfg_o);
  endtask

  initial begin
    test_reset();
    test_commit();
    test_short_long();
    test_collision();
    test_random();
    test_lock();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/const_gen_prog.md
Name: const_gen_prog

Overview:
- Programmable successor to the fixed tie-cell generator: still provides constant tie_hi/tie_lo banks, plus a CFG_W-bit register bank whose value is loaded at runtime over a 3-wire serial interface (enable, data, commit).
- Sits in the user area next to analog/mixed-signal macros that need static trim/config bits which are settable after tape-out, with a parametrised reset default.
- Optional sticky lock freezes the configuration until the next reset.

Parameters:
- NO_HI, 32, width of constant-one bank
- NO_LO, 96, width of constant-zero bank
- CFG_W, 16, width of programmable bank (legal range 1..64)
- CFG_RST, {CFG_W{1'b0}}, value of cfg_o after reset
- CNT_W, $clog2(CFG_W+2), bit-counter width (derived; do not override)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active high
- vccd1/vssd1  inout  1  power pins, present only under USE_POWER_PINS
- ser_en_i  in  1  shift enable; one bit is shifted per cycle while high
- ser_dat_i  in  1  serial data, MSB first
- commit_i  in  1  single-cycle strobe: apply shifted word
- lock_i  in  1  sticky lock request
- tie_hi  out  NO_HI  all ones, combinational
- tie_lo  out  NO_LO  all zeros, combinational
- cfg_o  out  CFG_W  registered programmable value
- done_o  out  1  one-cycle pulse, successful commit
- err_o  out  1  sticky frame error
- locked_o  out  1  lock status

Behaviour:
- Reset (async assert, sync release): cfg_o=CFG_RST, shift_q=0, cnt=0, done_o=0, err_o=0, locked_o=0, state=IDLE.
- tie_hi/tie_lo: constant, independent of clock and reset.
- States: IDLE, SHIFT.
  - IDLE: if ser_en_i is high, then shift_q <= {shift_q[CFG_W-2:0], ser_dat_i}, cnt=1, and state goes to SHIFT.
  - SHIFT: each cycle with ser_en_i high shifts one bit and increments cnt. cnt saturates at CFG_W+1 (overrun); shifting continues, so shift_q holds the last CFG_W bits.
  - Deasserting ser_en_i holds shift_q and cnt. The frame stays open until commit_i.
- Commit (commit_i high, any state):
  - Success requires cnt==CFG_W and locked_o==0.
  - On success: cfg_o <= shift_q at the next edge, done_o=1 for exactly that one cycle, so cfg_o and done_o update in the same cycle.
  - Rejected cases (cnt!=CFG_W, including 0 and overrun; or locked): cfg_o is unchanged, err_o <= 1, done_o stays 0.
  - Either outcome: cnt<=0, state<=IDLE. shift_q is not cleared.
- Simultaneous ser_en_i and commit_i: commit wins; that cycle's ser_dat_i bit is discarded.
- Lock: lock_i high at an edge sets locked_o=1, held until reset.
  - Lock and commit in the same cycle: the commit is evaluated with the pre-lock value, so a valid commit succeeds.
  - While locked, shifting still works; commits are rejected and set err_o.
- err_o is cleared only by reset.
- CFG_W==1 is legal: a frame is a single bit.
- Reset during a shift: the partial frame is lost and cfg_o returns to CFG_RST.
- Inputs are synchronous to clk_i; synchronisation of external pins is outside this block.

Decomposition:
- Shared package (const_gen_pkg): state enum (IDLE=1'b0, SHIFT=1'b1) and a function computing CNT_W from CFG_W.
- Sub-module const_gen_shift: shift register plus saturating counter, outputs shift_q and cnt.
- Top level: FSM, commit/lock/error logic, constant banks.

Test Plan:
- Reset with CFG_W=16, CFG_RST=16'hA5C3 -> cfg_o=16'hA5C3, err_o=0, locked_o=0, tie_hi=all ones, tie_lo=all zeros.
- Shift 16 bits of 16'h1234 MSB-first, then commit_i -> next cycle cfg_o=16'h1234, done_o=1 for one cycle, err_o=0.
- Shift 15 bits then commit; separately shift 17 bits then commit -> cfg_o unchanged, err_o=1, done_o never asserted.
- Shift 16 bits of 16'hBEEF, pulse lock_i and commit_i in the same cycle -> cfg_o=16'hBEEF, locked_o=1. Then shift 16'h0000 and commit -> cfg_o stays 16'hBEEF, err_o=1.
- Shift 15 bits, then assert ser_en_i and commit_i together -> rejected (cnt=15), err_o=1, state returns to IDLE. A following clean 16-bit frame of 16'h00FF commits successfully.
- Assert rst_i asynchronously mid-frame after cfg_o=16'h1234 -> cfg_o=CFG_RST immediately, without waiting for a clock edge. After release, locked_o=0, err_o=0 and a fresh frame commits.
